cv32e40p_rf_ckpt_replay: RTL and testbench
==========================================

Name: cv32e40p_rf_ckpt_replay

Overview:
- Shadow-checkpoint and replay engine for the integer/FP register file, generalised to NUM_WPORTS write ports.
- Snoops every RF write port during normal operation into a shadow copy.
- On a recovery request, asserts core setback and streams the shadow contents back into the RF through NUM_WPORTS restore ports, then signals completion.
- Sits beside cv32e40p_core and drives its recover/regfile write-recovery ports.

Parameters:
- NUM_WPORTS, 2: RF write ports snooped and restore ports driven; 1..4.
- ADDR_WIDTH, 6: RF address width.
- DATA_WIDTH, 32: RF data width.
- NUM_REGS, 64: shadow entries. Must equal 2**ADDR_WIDTH and be a multiple of NUM_WPORTS.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- cap_we_i  in  NUM_WPORTS  snooped write enable per port
- cap_waddr_i  in  NUM_WPORTS*ADDR_WIDTH  snooped address; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- cap_wdata_i  in  NUM_WPORTS*DATA_WIDTH  snooped data, packed the same way
- recover_req_i  in  1  level request to start recovery
- setback_o  out  1  holds core in setback while busy
- recover_o  out  1  drives core recover_i; high during restore
- rest_we_o  out  NUM_WPORTS  restore write enables
- rest_waddr_o  out  NUM_WPORTS*ADDR_WIDTH  restore addresses
- rest_wdata_o  out  NUM_WPORTS*DATA_WIDTH  restore data
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse when restore completes
- parity_err_o  out  1  sticky parity error; exists only with the optional feature

Behaviour:
- Reset values: all shadow entries 0; FSM IDLE; restore counter 0.
- Reset values, outputs: setback_o, recover_o, busy_o, done_o, parity_err_o all 0; rest_* outputs all 0.
- Capture:
  - In IDLE, each rising edge writes cap_wdata_i[p] to shadow[cap_waddr_i[p]] for every p with cap_we_i[p]=1.
  - Address 0 is never written; entry 0 stays 0.
  - Two or more ports writing the same address in one cycle: the highest-index port wins, matching RF port-B priority.
  - Capture is frozen in every state other than IDLE.
- FSM states: IDLE, HALT, RESTORE, DONE.
  - IDLE -> HALT when recover_req_i=1. Writes snooped in that same cycle are still captured.
  - HALT: one cycle. setback_o=1, busy_o=1, no restore writes. Counter cleared to 0. -> RESTORE.
  - RESTORE: setback_o=1, recover_o=1, busy_o=1.
    - Each cycle, port p drives rest_waddr_o[p]=cnt+p, rest_wdata_o[p]=shadow[cnt+p], rest_we_o[p]=1.
    - Exception: rest_we_o[p]=0 when the address is 0.
    - cnt increments by NUM_WPORTS per cycle.
    - Last cycle is cnt=NUM_REGS-NUM_WPORTS; then -> DONE. No wrap.
    - Restore length is NUM_REGS/NUM_WPORTS cycles.
  - DONE: one cycle. done_o=1, setback_o=0, recover_o=0, busy_o=1. -> IDLE.
- Outside RESTORE, rest_we_o, rest_waddr_o and rest_wdata_o are 0. All outputs are registered from FSM state and counter, so no combinational path from inputs.
- recover_req_i is ignored while busy. If still high in DONE, the FSM returns to IDLE first and re-enters HALT on the next cycle (a level request re-triggers).
- Total latency, request to done_o: 1 + 1 + NUM_REGS/NUM_WPORTS + 1 edges. Default: 35 cycles.
- Reset asserted mid-operation: immediate return to reset values. Shadow contents are lost and no done_o is produced.

Optional Feature:
- Macro: CV32E40P_RF_CKPT_PARITY_EN.
- Defined:
  - Each shadow entry stores an even-parity bit computed on capture.
  - During RESTORE, a recomputed-parity mismatch on any enabled port sets parity_err_o, which stays sticky until reset.
  - Restore still completes with the stored data.
- Undefined: no parity storage, parity_err_o port absent, behaviour otherwise identical.

Test Plan:
- Basic replay, defaults:
  - Stimulus: capture x5=0xDEADBEEF via port 0 and x40=0x12345678 via port 1, then pulse recover_req_i.
  - Response: setback_o rises one cycle after the request. Restore spans 32 cycles. Address 5 is seen with data 0xDEADBEEF, address 40 with 0x12345678. done_o pulses at cycle 35.
- Same-address conflict:
  - Stimulus: port 0 writes x7=0x1 and port 1 writes x7=0x2 in the same cycle.
  - Response: replay drives address 7 with 0x2.
- x0 suppression:
  - Stimulus: cap_we_i[0]=1, address 0, data 0xFFFFFFFF.
  - Response: during replay, rest_we_o[0]=0 in the first RESTORE cycle and no write to address 0 occurs.
- Freeze and ignore while busy:
  - Stimulus: during RESTORE, drive cap_we_i=all-1s with new data, and pulse recover_req_i.
  - Response: shadow is unchanged (verified by a second recovery) and exactly one done_o pulse results.
- Mid-operation reset:
  - Stimulus: assert rst_ni low at RESTORE cycle 10.
  - Response: all outputs are 0 in the same cycle. A following recovery replays all-zero data.
- NUM_WPORTS=4, NUM_REGS=64:
  - Response: restore lasts 16 cycles with addresses cnt..cnt+3 per cycle.
  - With CV32E40P_RF_CKPT_PARITY_EN defined, force a parity-bit flip on x9 -> parity_err_o goes high in the cycle x9 is driven and stays high.

Source files
------------

// File: rtl/cv32e40p_rf_ckpt_replay_if.sv
// Bus bundle for the RF checkpoint/replay engine: snoop inputs, recovery
// request and the restore-port/status outputs.
// Optional: CV32E40P_RF_CKPT_PARITY_EN adds parity_err_o.
interface cv32e40p_rf_ckpt_replay_if #(
  parameter int unsigned NUM_WPORTS = 2,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [NUM_WPORTS-1:0]            cap_we_i;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] cap_waddr_i;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] cap_wdata_i;
  logic                             recover_req_i;
  logic                             setback_o;
  logic                             recover_o;
  logic [NUM_WPORTS-1:0]            rest_we_o;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] rest_waddr_o;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] rest_wdata_o;
  logic                             busy_o;
  logic                             done_o;
`ifdef CV32E40P_RF_CKPT_PARITY_EN
  logic                             parity_err_o;
`endif

  // Engine side
  modport slave (
    input  cap_we_i, cap_waddr_i, cap_wdata_i, recover_req_i,
    output setback_o, recover_o, rest_we_o, rest_waddr_o, rest_wdata_o, busy_o, done_o
`ifdef CV32E40P_RF_CKPT_PARITY_EN
    , output parity_err_o
`endif
  );

  // Core / environment side
  modport master (
    output cap_we_i, cap_waddr_i, cap_wdata_i, recover_req_i,
    input  setback_o, recover_o, rest_we_o, rest_waddr_o, rest_wdata_o, busy_o, done_o
`ifdef CV32E40P_RF_CKPT_PARITY_EN
    , input parity_err_o
`endif
  );

endinterface

// File: rtl/cv32e40p_rf_ckpt_replay.sv
// Shadow-checkpoint and replay engine for the register file. Snoops all RF
// write ports while idle; on recovery it halts the core and streams the
// shadow copy back through NUM_WPORTS restore ports.
// Optional: CV32E40P_RF_CKPT_PARITY_EN stores an even-parity bit per entry
// and raises a sticky parity_err_o on a mismatch during restore.
module cv32e40p_rf_ckpt_replay #(
  parameter int unsigned NUM_WPORTS = 2,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 64
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  cv32e40p_rf_ckpt_replay_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHalt, StRestore, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastCnt = ADDR_WIDTH'(NUM_REGS - NUM_WPORTS);
  localparam logic [ADDR_WIDTH-1:0] Step    = ADDR_WIDTH'(NUM_WPORTS);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   shadow_d [NUM_REGS];
  logic [ADDR_WIDTH-1:0]   rd_addr  [NUM_WPORTS];

  logic [NUM_WPORTS-1:0]            rest_we;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] rest_waddr;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] rest_wdata;

`ifdef CV32E40P_RF_CKPT_PARITY_EN
  logic par_q [NUM_REGS];
  logic par_d [NUM_REGS];
  logic err_q, err_d;
  logic par_hit;
`endif

  // Capture: snoop enabled ports while idle; later ports override earlier ones
  always_comb begin
    shadow_d = shadow_q;
`ifdef CV32E40P_RF_CKPT_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == StIdle) begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (bus.cap_we_i[p] && (bus.cap_waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
          shadow_d[bus.cap_waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] =
              bus.cap_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
`ifdef CV32E40P_RF_CKPT_PARITY_EN
          par_d[bus.cap_waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] =
              ^bus.cap_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
      end
    end
  end

  // Shadow storage; cleared on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end

`ifdef CV32E40P_RF_CKPT_PARITY_EN
  // Parity storage and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        par_q[i] <= 1'b0;
      end
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  end
`endif

  // FSM state and restore counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.recover_req_i) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        cnt_d   = '0;
        state_d = StRestore;
      end
      StRestore: begin
        if (cnt_q == LastCnt) begin
          // Park at zero instead of wrapping past the last entry
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + Step;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Per-port read addresses for the current restore beat
  always_comb begin
    for (int p = 0; p < NUM_WPORTS; p++) begin
      rd_addr[p] = cnt_q + ADDR_WIDTH'(p);
    end
  end

  // Restore port drive; all zero outside RESTORE, x0 never written
  always_comb begin
    rest_we    = '0;
    rest_waddr = '0;
    rest_wdata = '0;
`ifdef CV32E40P_RF_CKPT_PARITY_EN
    par_hit    = 1'b0;
`endif
    if (state_q == StRestore) begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        rest_we[p]                               = (rd_addr[p] != '0);
        rest_waddr[p*ADDR_WIDTH +: ADDR_WIDTH]   = rd_addr[p];
        rest_wdata[p*DATA_WIDTH +: DATA_WIDTH]   = shadow_q[rd_addr[p]];
`ifdef CV32E40P_RF_CKPT_PARITY_EN
        if ((rd_addr[p] != '0) && ((^shadow_q[rd_addr[p]]) != par_q[rd_addr[p]])) begin
          par_hit = 1'b1;
        end
`endif
      end
    end
  end

`ifdef CV32E40P_RF_CKPT_PARITY_EN
  // Error flag latches any mismatch seen during restore
  always_comb begin
    err_d = err_q | par_hit;
  end

  // Visible in the same beat the bad entry is driven, then held by err_q
  assign bus.parity_err_o = err_q | par_hit;
`endif

  assign bus.setback_o    = (state_q == StHalt) || (state_q == StRestore);
  assign bus.recover_o    = (state_q == StRestore);
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.done_o       = (state_q == StDone);
  assign bus.rest_we_o    = rest_we;
  assign bus.rest_waddr_o = rest_waddr;
  assign bus.rest_wdata_o = rest_wdata;

endmodule

// File: tb/tb_cv32e40p_rf_ckpt_replay.sv
// Directed bench for cv32e40p_rf_ckpt_replay: a 2-port default instance and
// a 4-port instance. Parity checks compile only with CV32E40P_RF_CKPT_PARITY_EN.
module tb_cv32e40p_rf_ckpt_replay;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  cv32e40p_rf_ckpt_replay_if #(.NUM_WPORTS(2), .ADDR_WIDTH(6), .DATA_WIDTH(32)) if2 ();
  cv32e40p_rf_ckpt_replay_if #(.NUM_WPORTS(4), .ADDR_WIDTH(6), .DATA_WIDTH(32)) if4 ();

  cv32e40p_rf_ckpt_replay #(
    .NUM_WPORTS(2), .ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_REGS(64)
  ) dut2 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if2.slave)
  );

  cv32e40p_rf_ckpt_replay #(
    .NUM_WPORTS(4), .ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_REGS(64)
  ) dut4 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if4.slave)
  );

  // Results of the last 2-port recovery run
  logic [31:0] seen_d [64];
  bit          seen_w [64];
  int          r_setback, r_restore, r_done_cyc, r_done_n, r_first_we0;
  bit          r_timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap2(input logic [1:0] we, input logic [5:0] a0, input logic [31:0] d0,
                      input logic [5:0] a1, input logic [31:0] d1);
    if2.cap_we_i    = we;
    if2.cap_waddr_i = {a1, a0};
    if2.cap_wdata_i = {d1, d0};
    step();
    if2.cap_we_i = '0;
  endtask

  // Requests recovery on the 2-port DUT and records what it replays.
  // Cycle 1 is the request cycle. With disturb set, snoop writes and a
  // second request are injected in the 5th restore beat.
  task automatic run_rec2(input bit disturb);
    logic [5:0] a;
    for (int i = 0; i < 64; i++) begin
      seen_d[i] = '0;
      seen_w[i] = 1'b0;
    end
    r_setback = -1; r_restore = 0; r_done_cyc = -1; r_done_n = 0; r_first_we0 = -1;
    r_timeout = 1'b1;
    if2.recover_req_i = 1'b1;
    step();
    if2.recover_req_i = 1'b0;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      if (if2.setback_o && r_setback < 0) r_setback = cyc;
      if (if2.recover_o) begin
        r_restore++;
        if (r_restore == 1) r_first_we0 = int'(if2.rest_we_o[0]);
        for (int p = 0; p < 2; p++) begin
          if (if2.rest_we_o[p]) begin
            a = if2.rest_waddr_o[p*6 +: 6];
            seen_d[a] = if2.rest_wdata_o[p*32 +: 32];
            seen_w[a] = 1'b1;
          end
        end
      end
      if (if2.done_o) begin
        r_done_n++;
        r_done_cyc = cyc;
      end
      if (!if2.busy_o && cyc > 2) begin
        r_timeout = 1'b0;
        break;
      end
      if (disturb) begin
        if (if2.recover_o && r_restore == 5) begin
          if2.cap_we_i      = 2'b11;
          if2.cap_waddr_i   = {6'd40, 6'd5};
          if2.cap_wdata_i   = {32'h0000_0BAD, 32'h0000_0BAD};
          if2.recover_req_i = 1'b1;
        end else begin
          if2.cap_we_i      = '0;
          if2.recover_req_i = 1'b0;
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({if2.setback_o, if2.recover_o, if2.busy_o, if2.done_o} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {if2.setback_o, if2.recover_o, if2.busy_o, if2.done_o});
    end
    vec_cnt++;
    if ({if2.rest_we_o, if2.rest_waddr_o, if2.rest_wdata_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_rest: got we=%b addr=%h data=%h expected all 0",
               if2.rest_we_o, if2.rest_waddr_o, if2.rest_wdata_o);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if ({if2.busy_o, if4.busy_o} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_idle: got busy %b expected 00", {if2.busy_o, if4.busy_o});
    end
  endtask

  task automatic test_basic();
    cap2(2'b11, 6'd5, 32'hDEAD_BEEF, 6'd40, 32'h1234_5678);
    run_rec2(1'b0);
    vec_cnt++;
    if (r_timeout !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_timeout: got timeout=%0d expected 0", r_timeout);
    end
    vec_cnt++;
    if (r_setback != 2) begin
      err_cnt++;
      $display("FAIL basic_setback_cycle: got %0d expected 2", r_setback);
    end
    vec_cnt++;
    if (r_restore != 32) begin
      err_cnt++;
      $display("FAIL basic_restore_len: got %0d expected 32", r_restore);
    end
    vec_cnt++;
    if (r_done_cyc != 35 || r_done_n != 1) begin
      err_cnt++;
      $display("FAIL basic_done: got cycle %0d pulses %0d expected cycle 35 pulses 1",
               r_done_cyc, r_done_n);
    end
    vec_cnt++;
    if (!seen_w[5] || seen_d[5] !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL basic_x5: got we=%0d data=%h expected 1 deadbeef", seen_w[5], seen_d[5]);
    end
    vec_cnt++;
    if (!seen_w[40] || seen_d[40] !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL basic_x40: got we=%0d data=%h expected 1 12345678",
               seen_w[40], seen_d[40]);
    end
  endtask

  task automatic test_conflict();
    cap2(2'b11, 6'd7, 32'h1, 6'd7, 32'h2);
    run_rec2(1'b0);
    vec_cnt++;
    if (seen_d[7] !== 32'h2) begin
      err_cnt++;
      $display("FAIL conflict_x7: got %h expected 00000002", seen_d[7]);
    end
    vec_cnt++;
    if (seen_d[5] !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL conflict_keep_x5: got %h expected deadbeef", seen_d[5]);
    end
  endtask

  task automatic test_x0();
    cap2(2'b01, 6'd0, 32'hFFFF_FFFF, 6'd0, 32'h0);
    run_rec2(1'b0);
    vec_cnt++;
    if (r_first_we0 != 0) begin
      err_cnt++;
      $display("FAIL x0_first_we: got %0d expected 0", r_first_we0);
    end
    vec_cnt++;
    if (seen_w[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL x0_written: got %0d expected 0", seen_w[0]);
    end
  endtask

  task automatic test_freeze();
    run_rec2(1'b1);
    vec_cnt++;
    if (r_done_n != 1) begin
      err_cnt++;
      $display("FAIL freeze_done_count: got %0d expected 1", r_done_n);
    end
    run_rec2(1'b0);
    vec_cnt++;
    if (seen_d[5] !== 32'hDEAD_BEEF || seen_d[40] !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL freeze_shadow: got x5=%h x40=%h expected deadbeef 12345678",
               seen_d[5], seen_d[40]);
    end
  endtask

  // Level request held through DONE: one idle cycle, then HALT again
  task automatic test_back_to_back();
    int n;
    if2.recover_req_i = 1'b1;
    n = 0;
    while (!if2.done_o && n < 60) begin
      step();
      n++;
    end
    vec_cnt++;
    if (if2.done_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_done_wait: got done=%b expected 1", if2.done_o);
    end
    step();
    vec_cnt++;
    if (if2.busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_idle_gap: got busy=%b expected 0", if2.busy_o);
    end
    step();
    if2.recover_req_i = 1'b0;
    vec_cnt++;
    if ({if2.setback_o, if2.busy_o, if2.recover_o} !== 3'b110) begin
      err_cnt++;
      $display("FAIL b2b_rehalt: got %b expected 110",
               {if2.setback_o, if2.busy_o, if2.recover_o});
    end
    n = 0;
    while (if2.busy_o && n < 60) begin
      step();
      n++;
    end
    vec_cnt++;
    if (if2.busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_finish: got busy=%b expected 0", if2.busy_o);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int nz;
    if2.recover_req_i = 1'b1;
    step();
    if2.recover_req_i = 1'b0;
    n = 0;
    while (!if2.recover_o && n < 10) begin
      step();
      n++;
    end
    repeat (9) step();
    vec_cnt++;
    if (if2.rest_waddr_o !== {6'd19, 6'd18}) begin
      err_cnt++;
      $display("FAIL midrst_beat10: got addr=%h expected %h", if2.rest_waddr_o, {6'd19, 6'd18});
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({if2.setback_o, if2.recover_o, if2.busy_o, if2.done_o, if2.rest_we_o,
         if2.rest_waddr_o, if2.rest_wdata_o} !== '0) begin
      err_cnt++;
      $display("FAIL midrst_outputs: got sb=%b rc=%b bz=%b dn=%b we=%b expected all 0",
               if2.setback_o, if2.recover_o, if2.busy_o, if2.done_o, if2.rest_we_o);
    end
    step();
    rst_n = 1'b1;
    step();
    run_rec2(1'b0);
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      if (seen_d[i] !== 32'h0) nz++;
    end
    vec_cnt++;
    if (nz != 0 || r_done_n != 1) begin
      err_cnt++;
      $display("FAIL midrst_replay_zero: got nonzero=%0d done=%0d expected 0 and 1", nz, r_done_n);
    end
  endtask

  task automatic test_wports4();
    int n;
    int bad_addr;
    logic [5:0] exp_a;
    if4.cap_we_i    = 4'b1100;
    if4.cap_waddr_i = {6'd62, 6'd9, 6'd0, 6'd0};
    if4.cap_wdata_i = {32'h0000_CAFE, 32'h0000_0003, 32'h0, 32'h0};
    step();
    if4.cap_we_i = '0;
`ifdef CV32E40P_RF_CKPT_PARITY_EN
    force dut4.par_q[9] = 1'b1;
`endif
    if4.recover_req_i = 1'b1;
    step();
    if4.recover_req_i = 1'b0;
    n = 0;
    while (!if4.recover_o && n < 10) begin
      step();
      n++;
    end
    bad_addr = 0;
    for (int k = 0; k < 16; k++) begin
      for (int p = 0; p < 4; p++) begin
        exp_a = 6'(4 * k + p);
        if (if4.rest_waddr_o[p*6 +: 6] !== exp_a) bad_addr++;
      end
      if (k == 0) begin
        vec_cnt++;
        if (if4.rest_we_o !== 4'b1110) begin
          err_cnt++;
          $display("FAIL w4_first_we: got %b expected 1110", if4.rest_we_o);
        end
      end
      if (k == 2) begin
        vec_cnt++;
        if (if4.rest_wdata_o[32 +: 32] !== 32'h3) begin
          err_cnt++;
          $display("FAIL w4_x9: got %h expected 00000003", if4.rest_wdata_o[32 +: 32]);
        end
      end
      if (k == 15) begin
        vec_cnt++;
        if (if4.rest_wdata_o[64 +: 32] !== 32'h0000_CAFE) begin
          err_cnt++;
          $display("FAIL w4_x62: got %h expected 0000cafe", if4.rest_wdata_o[64 +: 32]);
        end
      end
`ifdef CV32E40P_RF_CKPT_PARITY_EN
      if (k == 1 || k == 2) begin
        vec_cnt++;
        if (if4.parity_err_o !== (k == 2)) begin
          err_cnt++;
          $display("FAIL w4_parity_beat%0d: got %b expected %0d", k, if4.parity_err_o, k == 2);
        end
      end
`endif
      step();
    end
    vec_cnt++;
    if (bad_addr != 0) begin
      err_cnt++;
      $display("FAIL w4_addr_seq: got %0d wrong addresses expected 0", bad_addr);
    end
    vec_cnt++;
    if ({if4.recover_o, if4.done_o} !== 2'b01) begin
      err_cnt++;
      $display("FAIL w4_len16: got recover/done %b expected 01", {if4.recover_o, if4.done_o});
    end
`ifdef CV32E40P_RF_CKPT_PARITY_EN
    release dut4.par_q[9];
    step();
    vec_cnt++;
    if (if4.parity_err_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL w4_parity_sticky: got %b expected 1", if4.parity_err_o);
    end
`endif
  endtask

  initial begin
    if2.cap_we_i = '0; if2.cap_waddr_i = '0; if2.cap_wdata_i = '0; if2.recover_req_i = 1'b0;
    if4.cap_we_i = '0; if4.cap_waddr_i = '0; if4.cap_wdata_i = '0; if4.recover_req_i = 1'b0;
    test_reset();
    test_basic();
    test_conflict();
    test_x0();
    test_freeze();
    test_back_to_back();
    test_mid_reset();
    test_wports4();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
